// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM sequencer arbiter.
// Port 0 is the instruction cache, port 1 the data cache.
package ram_arb_pkg;

    localparam int NUM_PORTS = 2;
    localparam int PORT_I    = 0;
    localparam int PORT_D    = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie the port that was not served last wins.
// Purely combinational; the caller owns the last-grant register.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] pending,
    input  logic                 last_grant,
    output logic                 grant_valid,
    output logic                 grant
);

    always_comb begin
        grant_valid = |pending;
        if (pending == 2'b11) begin
            grant = ~last_grant;
        end else begin
            grant = pending[1];
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one ram_control sequencer between the instruction and data caches.
// One transaction in flight; address/data are latched at grant and held through the response.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  req_rd,
    input  logic [1:0]  req_wr,
    input  logic [31:0] req_addr0,
    input  logic [31:0] req_addr1,
    input  logic [31:0] req_wdata0,
    input  logic [31:0] req_wdata1,
    output logic [1:0]  done,
    output logic [31:0] rdata,
    output logic        err_timeout,
    output logic        ram_rd_start,
    output logic        ram_wr_start,
    output logic [31:0] ram_rd_addr_base,
    output logic [31:0] ram_wr_addr_base,
    output logic [31:0] ram_wr_data_in,
    input  logic        ram_rd_done,
    input  logic        ram_wr_done,
    input  logic [31:0] ram_rd_data_out
);

    state_t      state_q,      state_d;
    op_t         op_q,         op_d;
    logic        last_grant_q, last_grant_d;
    logic        gnt_q,        gnt_d;
    logic [31:0] addr_q,       addr_d;
    logic [31:0] wdata_q,      wdata_d;
    logic [3:0]  cnt_q,        cnt_d;
    logic [1:0]  done_q,       done_d;
    logic [31:0] rdata_q,      rdata_d;
    logic        err_q,        err_d;
    logic        rd_start_q,   rd_start_d;
    logic        wr_start_q,   wr_start_d;

    logic [NUM_PORTS-1:0] pending;
    logic                 arb_valid;
    logic                 arb_gnt;
    logic                 ram_match;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_pending
            assign pending[gi] = req_rd[gi] | req_wr[gi];
        end
    endgenerate

    rr_arb2 u_rr_arb2 (
        .pending     (pending),
        .last_grant  (last_grant_q),
        .grant_valid (arb_valid),
        .grant       (arb_gnt)
    );

    // Only the done strobe of the operation actually issued ends the wait.
    assign ram_match = (op_q == OP_WR) ? ram_wr_done : ram_rd_done;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        done_d       = 2'b00;
        rdata_d      = rdata_q;
        err_d        = err_q;
        rd_start_d   = 1'b0;
        wr_start_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    gnt_d = arb_gnt;
                    // A port asking for both gets its write served first.
                    op_d       = req_wr[arb_gnt] ? OP_WR : OP_RD;
                    rd_start_d = ~req_wr[arb_gnt];
                    wr_start_d = req_wr[arb_gnt];
                    addr_d     = (arb_gnt == 1'(PORT_D)) ? req_addr1  : req_addr0;
                    wdata_d    = (arb_gnt == 1'(PORT_D)) ? req_wdata1 : req_wdata0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = 4'd0;
                state_d = WAIT;
            end
            WAIT: begin
                if (ram_match) begin
                    if (op_q == OP_RD) begin
                        rdata_d = ram_rd_data_out;
                    end
                    done_d[gnt_q] = 1'b1;
                    state_d       = RESP;
                end else if (cnt_q == 4'(TIMEOUT - 1)) begin
                    // Abort but still release the requester so it never hangs.
                    err_d         = 1'b1;
                    rdata_d       = 32'd0;
                    done_d[gnt_q] = 1'b1;
                    state_d       = RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                last_grant_d = gnt_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            op_q         <= OP_RD;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            cnt_q        <= 4'd0;
            done_q       <= 2'b00;
            rdata_q      <= 32'd0;
            err_q        <= 1'b0;
            rd_start_q   <= 1'b0;
            wr_start_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            rd_start_q   <= rd_start_d;
            wr_start_q   <= wr_start_d;
        end
    end

    assign done             = done_q;
    assign rdata            = rdata_q;
    assign err_timeout      = err_q;
    assign ram_rd_start     = rd_start_q;
    assign ram_wr_start     = wr_start_q;
    assign ram_rd_addr_base = addr_q;
    assign ram_wr_addr_base = addr_q;
    assign ram_wr_data_in   = wdata_q;

endmodule
